alu: RTL and testbench



---
 rtl/alu.sv | 118 +++++++++++
 tb/tb_alu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// MIPS-subset 32-bit ALU: combinational operation decode on opcode/functioncode,
// result registered on the rising clock edge with one cycle of latency.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] read_data_1,
    input  logic [WIDTH-1:0] read_data_2,
    input  logic [4:0]       shmat,
    input  logic [5:0]       opcode,
    input  logic [5:0]       functioncode,
    output logic [WIDTH-1:0] result
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] slt_val;
    logic [WIDTH-1:0] sltu_val;
    logic [4:0]       var_sh;
    logic [WIDTH-1:0] alu_next;

    assign a        = read_data_1;
    assign b        = read_data_2;
    assign sum      = a + b;
    assign diff     = a - b;
    assign slt_val  = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
    assign sltu_val = {{(WIDTH-1){1'b0}}, (a < b)};
    assign var_sh   = a[4:0];

    // No handshake: inputs are sampled every rising edge, result valid one cycle later.
    always_comb begin
        alu_next = '0;
        case (opcode)
            OP_RTYPE: begin
                case (functioncode)
                    FN_ADD, FN_ADDU: alu_next = sum;
                    FN_SUB, FN_SUBU: alu_next = diff;
                    FN_AND:          alu_next = a & b;
                    FN_OR:           alu_next = a | b;
                    FN_XOR:          alu_next = a ^ b;
                    FN_NOR:          alu_next = ~(a | b);
                    FN_SLT:          alu_next = slt_val;
                    FN_SLTU:         alu_next = sltu_val;
                    FN_SLL:          alu_next = b << shmat;
                    FN_SRL:          alu_next = b >> shmat;
                    FN_SRA:          alu_next = $signed(b) >>> shmat;
                    FN_SLLV:         alu_next = b << var_sh;
                    FN_SRLV:         alu_next = b >> var_sh;
                    FN_SRAV:         alu_next = $signed(b) >>> var_sh;
                    default:         alu_next = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU:       alu_next = sum;
            OP_ANDI:                 alu_next = a & b;
            OP_ORI:                  alu_next = a | b;
            OP_XORI:                 alu_next = a ^ b;
            OP_SLTI:                 alu_next = slt_val;
            OP_SLTIU:                alu_next = sltu_val;
            OP_LUI:                  alu_next = {b[15:0], 16'h0000};
            OP_BEQ, OP_BNE:          alu_next = diff;
            // Load/store effective address
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW:     alu_next = sum;
            default:                 alu_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else begin
            result <= alu_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered MIPS-subset ALU.
// Inputs change on the falling edge; result is sampled 1ns after the rising edge.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [4:0]  shmat;
    logic [5:0]  opcode;
    logic [5:0]  functioncode;
    logic [31:0] result;

    int test_count = 0;
    int fail_count = 0;
    logic [31:0] exp_q[$];

    alu #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_data_1  (read_data_1),
        .read_data_2  (read_data_2),
        .shmat        (shmat),
        .opcode       (opcode),
        .functioncode (functioncode),
        .result       (result)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: apply one operation at the falling edge, return just after the next rising edge.
    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        @(negedge clk);
        opcode       = op;
        functioncode = fn;
        read_data_1  = a;
        read_data_2  = b;
        shmat        = sh;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if (result !== 32'h0) begin fail_count++; $display("FAIL reset_initial: got %h want %h", result, 32'h0); end
        test_count++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(6'b000000, 6'b100000, 32'h5, 32'h6, 5'd0);
        if (result !== 32'hB) begin fail_count++; $display("FAIL pre_reset_add: got %h want %h", result, 32'hB); end
        test_count++;
        // Assert reset mid-cycle, away from any edge
        #2 rst_n = 1'b0;
        #1;
        if (result !== 32'h0) begin fail_count++; $display("FAIL reset_async: got %h want %h", result, 32'h0); end
        test_count++;
        repeat (2) @(posedge clk);
        #1;
        if (result !== 32'h0) begin fail_count++; $display("FAIL reset_hold: got %h want %h", result, 32'h0); end
        test_count++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(6'b000000, 6'b100000, 32'h1, 32'h2, 5'd0);
        if (result !== 32'h3) begin fail_count++; $display("FAIL reset_release_add: got %h want %h", result, 32'h3); end
        test_count++;
    endtask

    task automatic test_arith();
        drive(6'b000000, 6'b100000, 32'h80000004, 32'h7FFFFFFC, 5'd0);
        if (result !== 32'h00000000) begin fail_count++; $display("FAIL add_wrap: got %h want %h", result, 32'h0); end
        test_count++;
        drive(6'b000000, 6'b100010, 32'h8000008D, 32'h8000000C, 5'd0);
        if (result !== 32'h00000081) begin fail_count++; $display("FAIL sub: got %h want %h", result, 32'h81); end
        test_count++;
        drive(6'b000000, 6'b100011, 32'h00000000, 32'h00000001, 5'd0);
        if (result !== 32'hFFFFFFFF) begin fail_count++; $display("FAIL subu_wrap: got %h want %h", result, 32'hFFFFFFFF); end
        test_count++;
        drive(6'b001000, 6'b001100, 32'h80000004, 32'h8000020C, 5'd7);
        if (result !== 32'h00000210) begin fail_count++; $display("FAIL addi: got %h want %h", result, 32'h210); end
        test_count++;
        drive(6'b100100, 6'b000000, 32'h8000008D, 32'h8000000C, 5'd0);
        if (result !== 32'h00000099) begin fail_count++; $display("FAIL lbu_addr: got %h want %h", result, 32'h99); end
        test_count++;
        drive(6'b000101, 6'b100000, 32'h00000010, 32'h00000003, 5'd0);
        if (result !== 32'h0000000D) begin fail_count++; $display("FAIL bne_sub: got %h want %h", result, 32'hD); end
        test_count++;
    endtask

    task automatic test_logic();
        drive(6'b000000, 6'b100100, 32'hAAAAAAAA, 32'hFFFF0000, 5'd0);
        if (result !== 32'hAAAA0000) begin fail_count++; $display("FAIL and: got %h want %h", result, 32'hAAAA0000); end
        test_count++;
        drive(6'b000000, 6'b100101, 32'hAAAAAAAA, 32'hFFFF0000, 5'd0);
        if (result !== 32'hFFFFAAAA) begin fail_count++; $display("FAIL or: got %h want %h", result, 32'hFFFFAAAA); end
        test_count++;
        drive(6'b000000, 6'b100110, 32'hAAAAAAAA, 32'hFFFF0000, 5'd0);
        if (result !== 32'h5555AAAA) begin fail_count++; $display("FAIL xor: got %h want %h", result, 32'h5555AAAA); end
        test_count++;
        drive(6'b000000, 6'b100111, 32'hAAAAAAAA, 32'hFFFF0000, 5'd0);
        if (result !== 32'h00005555) begin fail_count++; $display("FAIL nor: got %h want %h", result, 32'h00005555); end
        test_count++;
        drive(6'b001101, 6'b111111, 32'h12340000, 32'h0000ABCD, 5'd0);
        if (result !== 32'h1234ABCD) begin fail_count++; $display("FAIL ori: got %h want %h", result, 32'h1234ABCD); end
        test_count++;
    endtask

    task automatic test_shift();
        drive(6'b000000, 6'b000000, 32'h0, 32'h0000000D, 5'd3);
        if (result !== 32'h00000068) begin fail_count++; $display("FAIL sll: got %h want %h", result, 32'h68); end
        test_count++;
        drive(6'b000000, 6'b000011, 32'h0, 32'h8000020C, 5'd3);
        if (result !== 32'hF0000041) begin fail_count++; $display("FAIL sra: got %h want %h", result, 32'hF0000041); end
        test_count++;
        drive(6'b000000, 6'b000010, 32'h0, 32'h8000020C, 5'd2);
        if (result !== 32'h20000083) begin fail_count++; $display("FAIL srl: got %h want %h", result, 32'h20000083); end
        test_count++;
        drive(6'b000000, 6'b000111, 32'h80000004, 32'h8000020C, 5'd0);
        if (result !== 32'hF8000020) begin fail_count++; $display("FAIL srav: got %h want %h", result, 32'hF8000020); end
        test_count++;
        drive(6'b000000, 6'b000100, 32'h00000008, 32'h00000003, 5'd1);
        if (result !== 32'h00000300) begin fail_count++; $display("FAIL sllv: got %h want %h", result, 32'h300); end
        test_count++;
        drive(6'b000000, 6'b000110, 32'h0000001F, 32'h8000020C, 5'd0);
        if (result !== 32'h00000001) begin fail_count++; $display("FAIL srlv_31: got %h want %h", result, 32'h1); end
        test_count++;
        drive(6'b000000, 6'b000010, 32'h0, 32'h8000020C, 5'd31);
        if (result !== 32'h00000001) begin fail_count++; $display("FAIL srl_31: got %h want %h", result, 32'h1); end
        test_count++;
        drive(6'b000000, 6'b000011, 32'h0, 32'h8000020C, 5'd31);
        if (result !== 32'hFFFFFFFF) begin fail_count++; $display("FAIL sra_31: got %h want %h", result, 32'hFFFFFFFF); end
        test_count++;
        drive(6'b000000, 6'b000011, 32'h0, 32'h7000020C, 5'd31);
        if (result !== 32'h00000000) begin fail_count++; $display("FAIL sra_31_pos: got %h want %h", result, 32'h0); end
        test_count++;
        drive(6'b000000, 6'b000000, 32'h0, 32'h8000020C, 5'd0);
        if (result !== 32'h8000020C) begin fail_count++; $display("FAIL sll_0: got %h want %h", result, 32'h8000020C); end
        test_count++;
    endtask

    task automatic test_compare();
        drive(6'b000000, 6'b101011, 32'h8000000C, 32'h8000000D, 5'd0);
        if (result !== 32'h00000001) begin fail_count++; $display("FAIL sltu_lt: got %h want %h", result, 32'h1); end
        test_count++;
        drive(6'b000000, 6'b101010, 32'h80000000, 32'h00000001, 5'd0);
        if (result !== 32'h00000001) begin fail_count++; $display("FAIL slt_neg: got %h want %h", result, 32'h1); end
        test_count++;
        drive(6'b000000, 6'b101011, 32'h80000000, 32'h00000001, 5'd0);
        if (result !== 32'h00000000) begin fail_count++; $display("FAIL sltu_big: got %h want %h", result, 32'h0); end
        test_count++;
        drive(6'b001010, 6'b000000, 32'h00000005, 32'hFFFFFFFF, 5'd0);
        if (result !== 32'h00000000) begin fail_count++; $display("FAIL slti_ge: got %h want %h", result, 32'h0); end
        test_count++;
        drive(6'b001011, 6'b000000, 32'h00000005, 32'hFFFFFFFF, 5'd0);
        if (result !== 32'h00000001) begin fail_count++; $display("FAIL sltiu_lt: got %h want %h", result, 32'h1); end
        test_count++;
    endtask

    task automatic test_timing_undef();
        drive(6'b000000, 6'b100001, 32'h1, 32'h1, 5'd0);
        if (result !== 32'h00000002) begin fail_count++; $display("FAIL hold_setup: got %h want %h", result, 32'h2); end
        test_count++;
        @(negedge clk);
        read_data_1 = 32'h5;
        read_data_2 = 32'h5;
        #2;
        if (result !== 32'h00000002) begin fail_count++; $display("FAIL hold_between_edges: got %h want %h", result, 32'h2); end
        test_count++;
        @(posedge clk);
        #1;
        if (result !== 32'h0000000A) begin fail_count++; $display("FAIL hold_next_edge: got %h want %h", result, 32'hA); end
        test_count++;
        drive(6'b000000, 6'b111111, 32'h12345678, 32'h9ABCDEF0, 5'd4);
        if (result !== 32'h00000000) begin fail_count++; $display("FAIL bad_funct: got %h want %h", result, 32'h0); end
        test_count++;
        drive(6'b111111, 6'b100000, 32'h12345678, 32'h9ABCDEF0, 5'd4);
        if (result !== 32'h00000000) begin fail_count++; $display("FAIL bad_opcode: got %h want %h", result, 32'h0); end
        test_count++;
        drive(6'b001111, 6'b000000, 32'hFFFFFFFF, 32'h00001234, 5'd0);
        if (result !== 32'h12340000) begin fail_count++; $display("FAIL lui: got %h want %h", result, 32'h12340000); end
        test_count++;
    endtask

    // Consecutive-cycle operations, each checked against a hand-computed scoreboard entry.
    task automatic test_back_to_back();
        logic [31:0] exp;
        exp_q.push_back(32'h00000030);
        exp_q.push_back(32'h0000000F);
        exp_q.push_back(32'hFFFFFFF0);
        exp_q.push_back(32'h00000001);
        drive(6'b001001, 6'b000000, 32'h00000010, 32'h00000020, 5'd0);
        exp = exp_q.pop_front();
        if (result !== exp) begin fail_count++; $display("FAIL b2b_addiu: got %h want %h", result, exp); end
        test_count++;
        drive(6'b001100, 6'b000000, 32'hFFFFFFFF, 32'h0000000F, 5'd0);
        exp = exp_q.pop_front();
        if (result !== exp) begin fail_count++; $display("FAIL b2b_andi: got %h want %h", result, exp); end
        test_count++;
        drive(6'b001110, 6'b000000, 32'hFFFFFFFF, 32'h0000000F, 5'd0);
        exp = exp_q.pop_front();
        if (result !== exp) begin fail_count++; $display("FAIL b2b_xori: got %h want %h", result, exp); end
        test_count++;
        drive(6'b000100, 6'b000000, 32'h00000007, 32'h00000006, 5'd0);
        exp = exp_q.pop_front();
        if (result !== exp) begin fail_count++; $display("FAIL b2b_beq: got %h want %h", result, exp); end
        test_count++;
    endtask

    initial begin
        rst_n        = 1'b0;
        read_data_1  = '0;
        read_data_2  = '0;
        shmat        = '0;
        opcode       = '0;
        functioncode = '0;
        #1;
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_compare();
        test_timing_undef();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
